// File: rtl/add8_arbiter_pkg.sv
// Shared definitions for the two-port shared-adder arbiter.
// The arbitration policy is selected by ADD8_ARB_FIXED_PRIO_EN (see add8_arb_pick).
package add8_arbiter_pkg;

  localparam int W_DEF     = 8;
  localparam int SUM_W_DEF = W_DEF + 1;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  // 2'd3 is never entered; the FSM treats it like idle.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/add8_arb_pick.sv
// Winner select for the shared adder.
// Round-robin by default; ADD8_ARB_FIXED_PRIO_EN gives port 0 fixed priority.
module add8_arb_pick
  import add8_arbiter_pkg::*;
(
  input  logic clk,
  input  logic res,
  input  logic req0,
  input  logic req1,
  input  logic take,
  output logic win
);

`ifdef ADD8_ARB_FIXED_PRIO_EN
  logic unused_pick;
  assign unused_pick = ^{clk, res, take};
  assign win = req0 ? PORT0 : PORT1;
`else
  logic last_reg;

  always_ff @(posedge clk) begin
    if (!res) begin
      last_reg <= PORT1;
    end else if (take) begin
      last_reg <= win;
    end
  end

  // On a tie the port that did not win last time goes next.
  always_comb begin
    win = PORT0;
    if (req0 && req1) begin
      win = ~last_reg;
    end else if (req1) begin
      win = PORT1;
    end
  end
`endif

endmodule

// File: rtl/add8_arbiter.sv
// Two requesters share one W-bit adder: capture winner, add, hold result until accepted.
// Policy build option: ADD8_ARB_FIXED_PRIO_EN (fixed priority instead of round-robin).
module add8_arbiter
  import add8_arbiter_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         res,
  input  logic         req0,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  output logic         gnt0,
  input  logic         req1,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  output logic         gnt1,
  output logic [W:0]   sum,
  output logic         sum_id,
  output logic         sum_vld,
  input  logic         sum_rdy
);

  state_t       state_reg;
  logic [W-1:0] opa_reg;
  logic [W-1:0] opb_reg;
  logic         id_reg;
  logic [1:0]   gnt_reg;
  logic [W:0]   sum_reg;
  logic         sum_id_reg;
  logic         sum_vld_reg;

  logic win;
  logic take;

  assign take = (state_reg != ST_CALC) && (state_reg != ST_DONE) && (req0 || req1);

  add8_arb_pick u_pick (
    .clk  (clk),
    .res  (res),
    .req0 (req0),
    .req1 (req1),
    .take (take),
    .win  (win)
  );

  always_ff @(posedge clk) begin
    if (!res) begin
      state_reg   <= ST_IDLE;
      opa_reg     <= '0;
      opb_reg     <= '0;
      id_reg      <= PORT0;
      gnt_reg     <= 2'b00;
      sum_reg     <= '0;
      sum_id_reg  <= PORT0;
      sum_vld_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_CALC: begin
          sum_reg     <= {1'b0, opa_reg} + {1'b0, opb_reg};
          sum_id_reg  <= id_reg;
          sum_vld_reg <= 1'b1;
          gnt_reg     <= 2'b00;
          state_reg   <= ST_DONE;
        end
        ST_DONE: begin
          if (sum_rdy) begin
            sum_vld_reg <= 1'b0;
            state_reg   <= ST_IDLE;
          end
        end
        default: begin
          gnt_reg <= 2'b00;
          if (take) begin
            opa_reg   <= (win == PORT1) ? a1 : a0;
            opb_reg   <= (win == PORT1) ? b1 : b0;
            id_reg    <= win;
            gnt_reg   <= {win, ~win};
            state_reg <= ST_CALC;
          end else begin
            state_reg <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign gnt0    = gnt_reg[0];
  assign gnt1    = gnt_reg[1];
  assign sum     = sum_reg;
  assign sum_id  = sum_id_reg;
  assign sum_vld = sum_vld_reg;

endmodule
